riscv_alu_arbiter: RTL and testbench
====================================

RISCV_ALU_ARBITER -- requirements
Module: riscv_alu_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority (requester 0 always wins).
REQ-002 Port: clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 Port: rst, input, 1 bit, asynchronous active-high reset.
REQ-004 Port: req0_valid, input, 1 bit, requester 0 has an operation pending.
REQ-005 Port: req0_ready, output, 1 bit, requester 0 operation accepted this cycle.
REQ-006 Port: req0_op, input, 4 bits, ALU opcode encoded per the defs.v ALU_* codes.
REQ-007 Port: req0_a and req0_b, inputs, 32 bits each, operands.
REQ-008 Port: resp0_valid, output, 1 bit, result for requester 0 available.
REQ-009 Port: resp0_ready, input, 1 bit, requester 0 consumes the result.
REQ-010 Port: resp0_result, output, 32 bits, result for requester 0.
REQ-011 Ports req1_valid, req1_ready, req1_op, req1_a, req1_b, resp1_valid, resp1_ready and resp1_result shall be identical in direction, width and meaning to their requester-0 counterparts.
REQ-012 Port: busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-013 Port: grant_id, output, 1 bit, index of the requester currently owning the ALU; holds its last value while in IDLE.

Function
REQ-014 The block shall instantiate exactly one riscv_alu, and both requesters shall share it.
REQ-015 The FSM shall have three states: IDLE, EXEC and RESP.
REQ-016 IDLE behaviour:
- If any reqN_valid is high, a winner is chosen.
- reqN_ready is asserted combinationally for the winner only, in that same cycle.
- On the edge, the winner's op, a and b are latched, grant_id is set to the winner, and the FSM moves to EXEC.
REQ-017 If no request is valid in IDLE, the FSM shall stay in IDLE and both req*_ready outputs shall be 0.
REQ-018 reqN_ready shall be 0 in EXEC and RESP; requests arriving then wait, and requesters hold valid and data until ready.
REQ-019 EXEC behaviour:
- The ALU is driven only from the latched opcode and operands.
- The ALU output is registered into the result register on the edge.
- The FSM moves to RESP.
- EXEC lasts exactly 1 cycle.
REQ-020 RESP behaviour:
- respN_valid is 1 for N = grant_id only; the other resp valid stays 0.
- respN_result shows the registered result; the non-granted result port drives 0.
- Valid and result hold stable until respN_ready is high on an edge; the FSM then returns to IDLE.
REQ-021 Latency: a request accepted on edge k shall see respN_valid high from edge k+2 onward.
REQ-022 Throughput: at most one operation per 3 cycles, with no back-to-back acceptance.
REQ-023 Arbitration with RR_EN=1:
- A priority pointer selects the winner when both requests are valid.
- When a single request is valid, that request wins regardless of the pointer.
- On the RESP-to-IDLE transition, the pointer is set to the non-granted index.
REQ-024 Arbitration with RR_EN=0: requester 0 wins whenever req0_valid is high, and the pointer is ignored.
REQ-025 Opcodes that are not defined ALU_* codes shall complete normally with result 0, with no error signalling.
REQ-026 Shift operations shall use latched b[4:0] only; a and b arithmetic shall be 32-bit modulo 2^32 with no carry or overflow output.
REQ-027 A request whose valid drops before acceptance shall simply not be granted, with no side effects.

Reset
REQ-028 While rst is high, the following shall hold:
- FSM is in IDLE.
- Priority pointer is 0.
- grant_id, busy, all ready and all resp valid outputs are 0.
- Result register, latched op and latched operands are 0.
- Both resp result ports drive 0.
REQ-029 Reset asserted in EXEC or RESP shall drop the in-flight operation immediately, with no response delivered; after release the block shall return to IDLE with the pointer at 0.
REQ-030 After rst deasserts, the first acceptance shall be possible on the first clock edge.

Verification
REQ-031 Single ADD: req0 ADD a=5, b=7 accepted at edge k -> resp0_valid at k+2, result 12, resp1_valid stays 0.
REQ-032 Simultaneous with RR_EN=1 after reset: both valid, req0 SUB 10-3 and req1 XOR 0xF0^0x0F -> req0 is served first with result 7, then req1 with result 0xFF; repeat both valid -> req0 is served first again.
REQ-033 Backpressure: resp0_ready held low for 5 cycles in RESP -> resp0_valid and resp0_result stable for all 5 cycles, req1_ready stays 0, busy=1 throughout.
REQ-034 Arithmetic and shifts: SHIFTR_ARITH a=0x80000000, b=0x24 -> 0xF8000000 (shift by 4); ADD 0xFFFFFFFF+1 -> 0; undefined opcode 4'hF -> 0.
REQ-035 Fixed priority with RR_EN=0: both requesters continuously valid -> req0 is granted every transaction and req1 is never granted.
REQ-036 Reset mid-EXEC: rst pulsed during EXEC -> busy and all valid outputs drop to 0 asynchronously; after release, a fresh req1 request completes normally with the correct result.

Source files
------------

// File: rtl/riscv_alu_arbiter.sv
// Purpose: two-requester front end that time-shares a single riscv_alu through an IDLE/EXEC/RESP FSM.
// Latency: a request accepted on edge k raises its resp valid after edge k+1, so it is first sampled high on edge k+2. Throughput is one operation per 3 cycles.
// Backpressure: req ready is offered only in IDLE. A pending response holds valid and result until its resp ready is seen on an edge.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/ready         request handshake for requester N (N = 0, 1)
//   reqN_op/a/b              ALU opcode (riscv_alu_pkg::ALU_*) and 32-bit operands
//   respN_valid/ready        response handshake for requester N
//   respN_result             registered result; 0 unless requester N is the one being answered
//   busy                     FSM is not in IDLE
//   grant_id                 requester owning the ALU; holds its value through IDLE

package riscv_alu_pkg;
    localparam logic [3:0] ALU_ADD          = 4'h0;
    localparam logic [3:0] ALU_SUB          = 4'h1;
    localparam logic [3:0] ALU_AND          = 4'h2;
    localparam logic [3:0] ALU_OR           = 4'h3;
    localparam logic [3:0] ALU_XOR          = 4'h4;
    localparam logic [3:0] ALU_SLT          = 4'h5;
    localparam logic [3:0] ALU_SLTU         = 4'h6;
    localparam logic [3:0] ALU_SHIFTL       = 4'h7;
    localparam logic [3:0] ALU_SHIFTR       = 4'h8;
    localparam logic [3:0] ALU_SHIFTR_ARITH = 4'h9;
endpackage

// Purpose: combinational 32-bit RISC-V style ALU; any undefined opcode yields 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module riscv_alu (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    import riscv_alu_pkg::*;

    logic [4:0] shamt;

    always_comb begin
        shamt  = b[4:0];
        result = '0;
        case (op)
            ALU_ADD:          result = a + b;
            ALU_SUB:          result = a - b;
            ALU_AND:          result = a & b;
            ALU_OR:           result = a | b;
            ALU_XOR:          result = a ^ b;
            ALU_SLT:          result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:         result = {31'b0, a < b};
            ALU_SHIFTL:       result = a << shamt;
            ALU_SHIFTR:       result = a >> shamt;
            ALU_SHIFTR_ARITH: result = $signed(a) >>> shamt;
            default:          result = '0;
        endcase
    end
endmodule

module riscv_alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_result,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_result,
    output logic        busy,
    output logic        grant_id
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        grant_q, grant_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;

    logic        any_req;
    logic        winner;
    logic        resp_ack;
    logic        in_idle;
    logic        in_resp;
    logic [31:0] alu_result;

    // The ALU only ever sees the latched request, never the live inputs.
    riscv_alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    // Pointer only breaks ties; a lone request always wins.
    always_comb begin
        any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            winner = RR_EN ? ptr_q : 1'b0;
        end else begin
            winner = req1_valid;
        end
    end

    always_comb begin
        in_idle  = (state_q == ST_IDLE);
        in_resp  = (state_q == ST_RESP);
        resp_ack = grant_q ? resp1_ready : resp0_ready;
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    op_d    = winner ? req1_op : req0_op;
                    a_d     = winner ? req1_a  : req0_a;
                    b_d     = winner ? req1_b  : req0_b;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ack) begin
                    // Hand the tie-break to whoever was just passed over.
                    ptr_d   = ~grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            grant_q  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    // Ready is masked by rst so a requester holding valid through reset
    // does not see a spurious acceptance while the FSM is forced to IDLE.
    always_comb begin
        req0_ready   = in_idle & ~rst & any_req & ~winner;
        req1_ready   = in_idle & ~rst & any_req &  winner;
        resp0_valid  = in_resp & ~grant_q;
        resp1_valid  = in_resp &  grant_q;
        resp0_result = resp0_valid ? result_q : 32'h0;
        resp1_result = resp1_valid ? result_q : 32'h0;
        busy         = ~in_idle;
        grant_id     = grant_q;
    end
endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Purpose: self-checking bench for riscv_alu_arbiter, one round-robin and one fixed-priority instance.
// Latency: n/a (testbench).
// Backpressure: response ready is held low for random/directed cycles to exercise result holding.
module tb_riscv_alu_arbiter;
    import riscv_alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Round-robin instance
    logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
    logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, resp0_result, resp1_result;
    logic        busy, grant_id;

    // Fixed-priority instance
    logic        f_req0_valid, f_req0_ready, f_resp0_valid, f_resp0_ready;
    logic        f_req1_valid, f_req1_ready, f_resp1_valid, f_resp1_ready;
    logic [3:0]  f_req0_op, f_req1_op;
    logic [31:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b, f_resp0_result, f_resp1_result;
    logic        f_busy, f_grant_id;

    riscv_alu_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .busy(busy), .grant_id(grant_id)
    );

    riscv_alu_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_op(f_req0_op),
        .req0_a(f_req0_a), .req0_b(f_req0_b),
        .resp0_valid(f_resp0_valid), .resp0_ready(f_resp0_ready), .resp0_result(f_resp0_result),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_op(f_req1_op),
        .req1_a(f_req1_a), .req1_b(f_req1_b),
        .resp1_valid(f_resp1_valid), .resp1_ready(f_resp1_ready), .resp1_result(f_resp1_result),
        .busy(f_busy), .grant_id(f_grant_id)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int rr_ptr = 0;   // model of which requester wins a tie

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference ALU written from the opcode definitions with plain arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            ALU_ADD:          return a + b;
            ALU_SUB:          return a - b;
            ALU_AND:          return a & b;
            ALU_OR:           return a | b;
            ALU_XOR:          return a ^ b;
            ALU_SLT:          return ((a[31] != b[31]) ? a[31] : (a < b)) ? 32'd1 : 32'd0;
            ALU_SLTU:         return (a < b) ? 32'd1 : 32'd0;
            ALU_SHIFTL:       return a << sh;
            ALU_SHIFTR:       return a >> sh;
            ALU_SHIFTR_ARITH: return a[31] ? ~((~a) >> sh) : (a >> sh);
            default:          return 32'd0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rr_ptr = 0;
    endtask

    // Entered at a negedge with request inputs already applied and the FSM in IDLE.
    // w: expected winner, exp: expected result, hold: extra RESP cycles with ready low.
    task automatic serve(input string tag, input int w, input logic [31:0] exp, input int hold);
        logic [1:0] vexp;
        vexp = (w == 1) ? 2'b10 : 2'b01;
        #1;
        chk({tag, "/rdy0"}, req0_ready, (w == 0));
        chk({tag, "/rdy1"}, req1_ready, (w == 1));
        @(negedge clk);
        chk({tag, "/exec_busy"}, busy, 1);
        chk({tag, "/exec_gnt"}, grant_id, w);
        chk({tag, "/exec_vld"}, {resp1_valid, resp0_valid}, 0);
        chk({tag, "/exec_rdy"}, {req1_ready, req0_ready}, 0);
        if (w == 0) req0_valid = 0; else req1_valid = 0;
        @(negedge clk);
        for (int i = 0; i <= hold; i++) begin
            chk({tag, "/resp_vld"}, {resp1_valid, resp0_valid}, vexp);
            chk({tag, "/resp_res"}, (w == 1) ? resp1_result : resp0_result, exp);
            chk({tag, "/resp_other"}, (w == 1) ? resp0_result : resp1_result, 0);
            chk({tag, "/resp_busy"}, busy, 1);
            chk({tag, "/resp_rdy"}, {req1_ready, req0_ready}, 0);
            if (i == hold) begin
                if (w == 1) resp1_ready = 1; else resp0_ready = 1;
            end
            @(negedge clk);
        end
        resp0_ready = 0; resp1_ready = 0;
        chk({tag, "/idle_busy"}, busy, 0);
        chk({tag, "/idle_vld"}, {resp1_valid, resp0_valid}, 0);
        chk({tag, "/idle_gnt"}, grant_id, w);
        rr_ptr = 1 - w;
    endtask

    initial begin
        logic [31:0] exp;
        int          w;
        int          v;
        int          seen;

        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        req0_op = 0; req0_a = 0; req0_b = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        f_req0_valid = 0; f_req1_valid = 0; f_resp0_ready = 1; f_resp1_ready = 1;
        f_req0_op = 0; f_req0_a = 0; f_req0_b = 0; f_req1_op = 0; f_req1_a = 0; f_req1_b = 0;

        // Reset state, with requests pending to show ready is masked.
        @(negedge clk);
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rst/busy", busy, 0);
        chk("rst/gnt", grant_id, 0);
        chk("rst/rdy", {req1_ready, req0_ready}, 0);
        chk("rst/vld", {resp1_valid, resp0_valid}, 0);
        chk("rst/res0", resp0_result, 0);
        chk("rst/res1", resp1_result, 0);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        rr_ptr = 0;

        // Single ADD, accepted on the first edge after reset release.
        req0_op = ALU_ADD; req0_a = 5; req0_b = 7; req0_valid = 1;
        serve("add", 0, 32'd12, 0);

        // Simultaneous requests from a fresh pointer.
        do_reset();
        req0_op = ALU_SUB; req0_a = 10; req0_b = 3;
        req1_op = ALU_XOR; req1_a = 32'hF0; req1_b = 32'h0F;
        req0_valid = 1; req1_valid = 1;
        serve("sim_a", 0, 32'd7, 0);
        serve("sim_b", 1, 32'hFF, 0);
        req0_valid = 1; req1_valid = 1;
        serve("sim_c", 0, 32'd7, 0);
        serve("sim_d", 1, 32'hFF, 0);

        // Backpressure: req0 answer held 5 cycles while req1 waits.
        req0_op = ALU_OR; req0_a = 32'h1234_0000; req0_b = 32'h0000_5678;
        req1_op = ALU_AND; req1_a = 32'hFFFF_0000; req1_b = 32'h0F0F_0F0F;
        req0_valid = 1; req1_valid = 1;
        serve("bp", 0, 32'h1234_5678, 5);
        serve("bp_next", 1, 32'h0F0F_0000, 0);

        // Arithmetic corner cases.
        req0_op = ALU_SHIFTR_ARITH; req0_a = 32'h8000_0000; req0_b = 32'h24; req0_valid = 1;
        serve("sra", 0, 32'hF800_0000, 0);
        req0_op = ALU_ADD; req0_a = 32'hFFFF_FFFF; req0_b = 1; req0_valid = 1;
        serve("add_wrap", 0, 32'h0, 0);
        req0_op = 4'hF; req0_a = 32'hDEAD_BEEF; req0_b = 32'h1; req0_valid = 1;
        serve("undef_op", 0, 32'h0, 0);

        // Reset in EXEC drops the operation; a fresh req1 then completes.
        req1_op = ALU_SUB; req1_a = 32'd100; req1_b = 32'd1; req1_valid = 1;
        @(negedge clk);
        chk("mid/busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid/rst_busy", busy, 0);
        chk("mid/rst_vld", {resp1_valid, resp0_valid}, 0);
        chk("mid/rst_rdy", {req1_ready, req0_ready}, 0);
        chk("mid/rst_gnt", grant_id, 0);
        @(negedge clk);
        rst = 1'b0;
        rr_ptr = 0;
        req1_op = ALU_SHIFTL; req1_a = 32'h0000_0003; req1_b = 32'h0000_0104;
        serve("post_rst", 1, 32'h30, 0);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 24; t++) begin
            v = $urandom_range(1, 3);
            req0_op = 4'($urandom_range(0, 15)); req0_a = $urandom; req0_b = $urandom;
            req1_op = 4'($urandom_range(0, 15)); req1_a = $urandom; req1_b = $urandom;
            req0_valid = v[0]; req1_valid = v[1];
            w   = (v == 3) ? rr_ptr : ((v == 2) ? 1 : 0);
            exp = (w == 1) ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
            serve("rnd", w, exp, $urandom_range(0, 3));
        end
        req0_valid = 0; req1_valid = 0;

        // Fixed priority: both requesters continuously valid, responses always taken.
        f_req0_op = ALU_SLT; f_req0_a = $urandom; f_req0_b = $urandom;
        f_req1_op = ALU_ADD; f_req1_a = $urandom; f_req1_b = $urandom;
        exp = ref_alu(f_req0_op, f_req0_a, f_req0_b);
        f_req0_valid = 1; f_req1_valid = 1;
        #1;
        chk("fp/rdy0", f_req0_ready, 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("fp/rdy1", f_req1_ready, 0);
            chk("fp/vld1", f_resp1_valid, 0);
            chk("fp/gnt", f_grant_id, 0);
            if (f_resp0_valid) begin
                seen++;
                chk("fp/res", f_resp0_result, exp);
            end
        end
        chk("fp/count", seen, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
